// File: rtl/rk_crt_seq.sv
// rk_crt_seq: character-row sequencer for the Radio-86RK video stage.
// Tracks frame/row/scanline from hr/vr, double-buffers one character row
// fetched over a DMA req/ack handshake, and emits per-cell code and strobes.
module rk_crt_seq #(
  parameter int COLS    = 78,
  parameter int ROWS    = 30,
  parameter int LINES   = 10,
  parameter int UL_LINE = 9,
  parameter int VSKIP   = 11
) (
  input  logic       clk50mhz,
  input  logic       reset_n,
  input  logic       cce,
  input  logic       hr,
  input  logic       vr,
  input  logic       display_en,
  input  logic [6:0] cursor_x,
  input  logic [4:0] cursor_y,
  output logic       dma_req,
  input  logic       dma_ack,
  input  logic [7:0] dma_data,
  output logic [3:0] line,
  output logic [6:0] ichar,
  output logic       vsp,
  output logic       lten,
  output logic       rvv,
  output logic       underrun
);

  localparam logic [6:0] C_COLS  = 7'(COLS);
  localparam logic [6:0] C_WLAST = 7'(COLS - 1);
  localparam logic [5:0] C_ROWS  = 6'(ROWS);
  localparam logic [3:0] C_LAST  = 4'(LINES - 1);
  localparam logic [3:0] C_UL    = 4'(UL_LINE);
  localparam logic [4:0] C_SKIP  = 5'(VSKIP);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic       r_hr, r_hr_d, r_vr, r_vr_d;
  logic [6:0] r_col;
  logic [3:0] r_line;
  logic [5:0] r_row;
  logic [4:0] r_skip;
  logic [4:0] r_frame;
  logic       r_disp;      // buffer currently being displayed (1 = buf1)
  logic       r_rowblank;  // displayed row arrived incomplete
  logic       r_underrun;
  logic [1:0] r_fstate;
  logic [6:0] r_wr_idx;
  logic [6:0] r_ichar;
  logic       r_vsp, r_lten, r_rvv;
  logic [7:0] r_buf0 [COLS];
  logic [7:0] r_buf1 [COLS];

  logic       w_hr_rise, w_vr_rise;
  logic [6:0] w_col_n;
  logic [3:0] w_line_n;
  logic [5:0] w_row_n;
  logic [4:0] w_skip_n;
  logic [4:0] w_frame_n;
  logic       w_swap, w_fill_start, w_under_hit, w_rowblank_n, w_disp_n, w_we;
  logic [7:0] w_byte;
  logic       w_blank, w_cur, w_vsp;

  assign w_hr_rise    = r_hr & ~r_hr_d;
  assign w_vr_rise    = r_vr & ~r_vr_d;
  assign w_under_hit  = w_swap && (r_fstate == S_FETCH);
  assign w_rowblank_n = w_vr_rise ? 1'b0 : (w_swap ? w_under_hit : r_rowblank);
  assign w_disp_n     = r_disp ^ w_swap;
  // Acks landing on a fill restart or an abort belong to the dead fill.
  assign w_we         = dma_ack && (r_fstate == S_FETCH) && !w_swap && !w_fill_start;

  // Frame/line sequencing: next counters plus swap/fill-start decisions.
  // The vr edge wins over a coincident hr edge.
  always_comb begin
    w_col_n      = r_col;
    w_line_n     = r_line;
    w_row_n      = r_row;
    w_skip_n     = r_skip;
    w_frame_n    = r_frame;
    w_swap       = 1'b0;
    w_fill_start = 1'b0;
    if (w_vr_rise) begin
      w_skip_n     = C_SKIP;
      w_row_n      = '0;
      w_line_n     = '0;
      w_frame_n    = r_frame + 5'd1;
      w_fill_start = 1'b1;
    end else if (w_hr_rise) begin
      w_col_n = '0;
      if (r_skip != '0) begin
        w_skip_n = r_skip - 5'd1;
        if (r_skip == 5'd1) begin
          w_swap       = 1'b1;
          w_fill_start = (C_ROWS > 6'd1);
        end
      end else if (r_line == C_LAST) begin
        w_line_n = '0;
        if (r_row < C_ROWS) w_row_n = r_row + 6'd1;
        w_swap       = 1'b1;
        w_fill_start = ((w_row_n + 6'd1) < C_ROWS);
      end else begin
        w_line_n = r_line + 4'd1;
      end
    end
  end

  // Cell lookup and strobe decode, using post-edge col/line/row.
  always_comb begin
    w_byte = 8'h00;
    if (w_col_n < C_COLS) w_byte = w_disp_n ? r_buf1[w_col_n] : r_buf0[w_col_n];
    w_blank = (w_col_n >= C_COLS) || (w_skip_n != '0) || (w_row_n >= C_ROWS) ||
              !display_en || w_rowblank_n || w_line_n[3];
    w_cur   = (w_col_n == cursor_x) && (w_row_n == {1'b0, cursor_y}) &&
              (w_line_n == C_UL) && w_frame_n[4] && display_en;
    w_vsp   = w_blank & ~w_cur;
  end

  // Sequencer state, fill FSM and registered cell outputs.
  always_ff @(posedge clk50mhz) begin
    if (!reset_n) begin
      r_hr <= 1'b1; r_hr_d <= 1'b1; r_vr <= 1'b1; r_vr_d <= 1'b1;
      r_col <= '0; r_line <= '0; r_row <= '0; r_skip <= '0; r_frame <= '0;
      r_disp <= 1'b0; r_rowblank <= 1'b0; r_underrun <= 1'b0;
      r_fstate <= S_IDLE; r_wr_idx <= '0;
      r_ichar <= '0; r_vsp <= 1'b1; r_lten <= 1'b0; r_rvv <= 1'b0;
    end else begin
      r_hr <= hr; r_hr_d <= r_hr; r_vr <= vr; r_vr_d <= r_vr;
      r_line <= w_line_n; r_row <= w_row_n; r_skip <= w_skip_n; r_frame <= w_frame_n;
      r_disp <= w_disp_n; r_rowblank <= w_rowblank_n;
      if (w_vr_rise) r_underrun <= 1'b0;
      else if (w_under_hit) r_underrun <= 1'b1;
      if (cce) begin
        r_col   <= (w_col_n == 7'd127) ? w_col_n : w_col_n + 7'd1;
        r_lten  <= w_cur;
        r_vsp   <= w_vsp;
        r_rvv   <= ~w_vsp & w_byte[7];
        r_ichar <= w_vsp ? 7'd0 : w_byte[6:0];
      end else begin
        r_col <= w_col_n;
      end
      if (w_fill_start) begin
        r_fstate <= S_FETCH;
        r_wr_idx <= '0;
      end else if (w_under_hit) begin
        r_fstate <= S_IDLE;
      end else if (w_we) begin
        r_wr_idx <= r_wr_idx + 7'd1;
        if (r_wr_idx == C_WLAST) r_fstate <= S_DONE;
      end
    end
  end

  // Fill always targets the buffer not on display.
  always_ff @(posedge clk50mhz) begin
    if (w_we) begin
      if (r_disp) r_buf0[r_wr_idx] <= dma_data;
      else        r_buf1[r_wr_idx] <= dma_data;
    end
  end

  assign dma_req  = (r_fstate == S_FETCH);
  assign line     = r_line;
  assign ichar    = r_ichar;
  assign vsp      = r_vsp;
  assign lten     = r_lten;
  assign rvv      = r_rvv;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_rk_crt_seq.sv
// Bench for rk_crt_seq: compressed video timing, randomized DMA acks and
// display_en, a scanline-level reference model, and a table of spot cells.
module tb_rk_crt_seq;
  localparam int COLS = 78, ROWS = 30, LINES = 10, UL_LINE = 9, VSKIP = 11;

  logic clk50mhz = 1'b0;
  always #5 clk50mhz = ~clk50mhz;

  logic       reset_n, cce, hr, vr, display_en, dma_ack, dma_req;
  logic [6:0] cursor_x, ichar;
  logic [4:0] cursor_y;
  logic [7:0] dma_data;
  logic [3:0] line;
  logic       vsp, lten, rvv, underrun;

  rk_crt_seq #(.COLS(COLS), .ROWS(ROWS), .LINES(LINES), .UL_LINE(UL_LINE), .VSKIP(VSKIP)) dut (
    .clk50mhz(clk50mhz), .reset_n(reset_n), .cce(cce), .hr(hr), .vr(vr),
    .display_en(display_en), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .dma_req(dma_req), .dma_ack(dma_ack), .dma_data(dma_data), .line(line),
    .ichar(ichar), .vsp(vsp), .lten(lten), .rvv(rvv), .underrun(underrun));

  int n_cmp = 0, n_bad = 0;

  // reference model: where the beam is, in screen terms
  int m_skip = 0, m_row = 0, m_line = 0, m_col = 0, m_frame = 0;
  bit m_rowblank = 0, m_under = 0;
  int hold_row = 99;  // row whose DMA data is withheld
  int phase = -1;     // capture slot for spot table
  // DMA responder state
  int fill_row = 0, ack_idx = 0, fs_cd = 0, fs_row = 0;
  bit fs_arm = 0, last_ack = 0;

  bit [10:0] cap [2][6][10][89];

  typedef struct {
    int ph; int r; int l; int c;
    logic [6:0] ich; logic vs; logic lt; logic rv;
  } spot_t;
  spot_t tbl [15];

  function automatic logic [7:0] mem(int r, int c);
    if (r == 1 && c == 3) return 8'hC1;
    return {(r >= 3 && (r + c) % 7 == 0), 7'(c + 32 + r)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic arm(input int r);
    fs_arm = 1; fs_cd = 2; fs_row = r;
  endtask

  task automatic check_cell();
    logic [7:0] b;
    logic blank, cur, e_vsp, e_rvv;
    logic [6:0] e_ich;
    string loc;
    b = (m_col < COLS && m_row < ROWS) ? mem(m_row, m_col) : 8'h00;
    blank = (m_col >= COLS) || (m_skip > 0) || (m_row >= ROWS) || !display_en ||
            m_rowblank || (m_line >= 8);
    cur = (m_col == int'(cursor_x)) && (m_row == int'(cursor_y)) && (m_line == UL_LINE) &&
          ((m_frame & 16) != 0) && display_en;
    e_vsp = blank && !cur;
    e_ich = e_vsp ? 7'd0 : b[6:0];
    e_rvv = e_vsp ? 1'b0 : b[7];
    loc = $sformatf("f%0d r%0d l%0d c%0d", m_frame, m_row, m_line, m_col);
    chk({"vsp ", loc}, vsp, e_vsp);
    chk({"lten ", loc}, lten, cur);
    chk({"rvv ", loc}, rvv, e_rvv);
    chk({"ichar ", loc}, ichar, e_ich);
    if (phase >= 0 && m_skip == 0 && m_row < 6 && m_col < 89)
      cap[phase][m_row][m_line][m_col] = {1'b1, lten, vsp, rvv, ichar};
    if (m_col < 127) m_col++;
  endtask

  // One clock: drive cce and a random DMA response at the negedge,
  // then sample outputs at the following negedge.
  task automatic tick(input logic c);
    cce = c;
    if (fs_arm && fs_cd == 0) begin ack_idx = 0; fill_row = fs_row; fs_arm = 0; end
    if (dma_req && !fs_arm && fill_row != hold_row && ack_idx < COLS &&
        $urandom_range(0, 1) == 1) begin
      dma_ack = 1; dma_data = mem(fill_row, ack_idx); ack_idx++;
      last_ack = (ack_idx == COLS);
    end else begin
      dma_ack = 0; dma_data = 8'($urandom); last_ack = 0;
    end
    @(posedge clk50mhz);
    if (fs_cd > 0) fs_cd--;
    @(negedge clk50mhz);
    cce = 0; dma_ack = 0;
    if (last_ack) chk("dma_req_drop", dma_req, 0);
    if (c) check_cell();
  endtask

  task automatic model_hr();
    m_col = 0;
    if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) begin m_rowblank = 0; if (ROWS > 1) arm(1); end
    end else if (m_line == LINES - 1) begin
      m_line = 0;
      if (m_row < ROWS) m_row++;
      m_rowblank = (m_row == hold_row);
      if (m_rowblank) m_under = 1;
      if (m_row + 1 < ROWS) arm(m_row + 1);
    end else begin
      m_line++;
    end
    display_en = (m_row >= 3) ? ($urandom_range(0, 7) != 0) : 1'b1;
  endtask

  task automatic do_line();
    int old_line;
    hr = 0; repeat (3) tick(0);
    old_line = m_line;
    hr = 1; model_hr();
    tick(0); chk("line_hold", line, old_line);
    tick(1); chk("line_step", line, m_line);  // this cce coincides with the edge
    tick(0);
    for (int i = 1; i < 89; i++) begin tick(1); tick(0); end
    chk($sformatf("underrun r%0d l%0d", m_row, m_line), underrun, m_under);
  endtask

  task automatic do_vr();
    vr = 0; tick(0); tick(0);
    vr = 1;
    m_skip = VSKIP; m_row = 0; m_line = 0; m_frame = (m_frame + 1) % 32;
    m_under = 0; m_rowblank = 0; arm(0);
    repeat (4) tick(0);
    chk("underrun_vr", underrun, m_under);
    chk("line_vr", line, 0);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 0,  7'h20, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{0, 0, 0, 77, 7'h6D, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{0, 0, 0, 78, 7'h00, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{0, 0, 0, 88, 7'h00, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{0, 0, 5, 10, 7'h2A, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{0, 1, 0, 3,  7'h41, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{0, 1, 8, 3,  7'h00, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{0, 0, 9, 5,  7'h00, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{0, 2, 9, 5,  7'h00, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{0, 4, 0, 0,  7'h00, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{0, 4, 3, 20, 7'h00, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1, 2, 9, 5,  7'h27, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1, 2, 9, 4,  7'h00, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1, 2, 8, 5,  7'h00, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1, 1, 0, 3,  7'h41, 1'b0, 1'b0, 1'b1};

    reset_n = 0; cce = 0; hr = 1; vr = 1; display_en = 1;
    cursor_x = 7'd5; cursor_y = 5'd2; dma_ack = 0; dma_data = 8'h00;

    // reset, then a fill interrupted by reset
    repeat (3) tick(0);
    reset_n = 1; tick(0);
    vr = 0; tick(0); tick(0);
    vr = 1; fill_row = 0; ack_idx = 0;
    tick(0); chk("req_lat0", dma_req, 0);
    tick(0); chk("req_lat1", dma_req, 1);
    tick(0); tick(0);
    reset_n = 0;
    tick(0); chk("rst_req_drop", dma_req, 0);
    tick(0); tick(0);
    reset_n = 1; tick(0);
    chk("rst_vsp", vsp, 1);
    chk("rst_ichar", ichar, 0);
    chk("rst_lten", lten, 0);
    chk("rst_rvv", rvv, 0);
    chk("rst_line", line, 0);
    chk("rst_dma_req", dma_req, 0);
    chk("rst_underrun", underrun, 0);

    // frame 1: rows 0..5, row 4 starved of DMA data
    hold_row = 4; phase = 0;
    do_vr();
    for (int i = 0; i < VSKIP - 1 + 6 * LINES; i++) do_line();
    chk("underrun_set", underrun, 1);

    // frames 2..15 are short; frame 2 start must clear underrun
    phase = -1; hold_row = 99;
    do_vr();
    chk("underrun_clr", underrun, 0);
    for (int f = 3; f <= 15; f++) do_vr();

    // frame 16: blink phase on, cursor visible
    phase = 1;
    do_vr();
    for (int i = 0; i < VSKIP - 1 + 3 * LINES; i++) do_line();

    for (int i = 0; i < 15; i++)
      chk($sformatf("spot%0d f%0d r%0d l%0d c%0d", i, tbl[i].ph, tbl[i].r, tbl[i].l, tbl[i].c),
          {21'd0, cap[tbl[i].ph][tbl[i].r][tbl[i].l][tbl[i].c]},
          {21'd0, 1'b1, tbl[i].lt, tbl[i].vs, tbl[i].rv, tbl[i].ich});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
